syscon_wb_arbiter: RTL and testbench
====================================

SYSCON_WB_ARBITER -- requirements
Module: syscon_wb_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of BUSY cycles without slave ack before an error is returned (legal range 2..255).
REQ-002 The block SHALL have parameter SLV_AW, default 6, meaning the width of the address forwarded to the system-controller slave.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have ports i_m0_adr / i_m1_adr, input, 32 bits each: master 0 (CPU) and master 1 (debug) Wishbone address.
REQ-006 The block SHALL have ports i_m0_dat / i_m1_dat, input, 32 bits each: master write data.
REQ-007 The block SHALL have ports i_m0_sel / i_m1_sel, input, 4 bits each: master byte selects.
REQ-008 The block SHALL have ports i_m0_we, i_m0_cyc, i_m0_stb / i_m1_we, i_m1_cyc, i_m1_stb, input, 1 bit each: master Wishbone control.
REQ-009 The block SHALL have ports o_m0_rdt / o_m1_rdt, output, 32 bits each: read data returned to each master.
REQ-010 The block SHALL have ports o_m0_ack, o_m0_err / o_m1_ack, o_m1_err, output, 1 bit each: per-master termination.
REQ-011 The block SHALL have port o_s_adr, output, SLV_AW bits: slave address, equal to granted master adr[SLV_AW-1:0].
REQ-012 The block SHALL have ports o_s_dat (32), o_s_sel (4), o_s_we (1), o_s_cyc (1), o_s_stb (1), all outputs: the slave Wishbone request.
REQ-013 The block SHALL have ports i_s_rdt (32) and i_s_ack (1), inputs: the slave response.
REQ-014 The block SHALL have port o_grant, output, 2 bits: one-hot current owner (bit0 = m0, bit1 = m1), 00 when IDLE.

Function
REQ-015 The FSM SHALL have two states, IDLE and BUSY, plus registers owner (1 bit), last (1 bit) and tmo_cnt (8 bits).
REQ-016 A request from master N SHALL be i_mN_cyc & i_mN_stb.
REQ-017 In IDLE with exactly one request, the FSM SHALL move to BUSY on the next edge with owner set to that master.
REQ-018 In IDLE with both masters requesting, the grant SHALL go to the master that is not 'last' (round-robin).
REQ-019 On every grant, 'last' SHALL be updated to the granted master.
REQ-020 In IDLE, o_s_cyc, o_s_stb and o_grant SHALL be 0, and all master ack/err outputs SHALL be 0.
REQ-021 In BUSY, the slave request outputs SHALL be driven combinationally from the owner's inputs.
REQ-022 o_s_cyc and o_s_stb SHALL be gated by the owner's own cyc and stb respectively.
REQ-023 In BUSY, o_mN_ack for the owner SHALL equal i_s_ack combinationally, and o_mN_rdt for the owner SHALL equal i_s_rdt; the non-owner SHALL see rdt=0, ack=0, err=0.
REQ-024 On i_s_ack in BUSY, the FSM SHALL return to IDLE on the next edge, giving one mandatory IDLE cycle between transactions.
REQ-025 If the owner deasserts cyc while in BUSY (abort), the FSM SHALL return to IDLE on the next edge with no ack or err.
REQ-026 tmo_cnt SHALL be cleared on entry to BUSY and SHALL increment every BUSY cycle without ack.
REQ-027 When tmo_cnt = TIMEOUT_CYCLES-1 and i_s_ack=0, the block SHALL pulse the owner's o_mN_err for one cycle, force o_s_cyc=o_s_stb=0 in that cycle, and go to IDLE.
REQ-028 If i_s_ack and the timeout condition occur in the same cycle, ack SHALL win: ack=1 and err=0.
REQ-029 i_s_ack in IDLE SHALL be ignored.
REQ-030 Minimum latency SHALL be: request sampled at edge N, slave strobe asserted in cycle N+1, master ack in the same cycle as i_s_ack.

Reset
REQ-031 When i_rst_n=0 at a clock edge, the block SHALL set state=IDLE, owner=0, last=1 (so m0 wins the first contention) and tmo_cnt=0.
REQ-032 A reset asserted mid-transaction SHALL drop o_s_cyc/o_s_stb in the cycle after the edge without generating ack or err.
REQ-033 While in reset, all outputs SHALL be 0.

Verification
REQ-034 Single m0 write (adr=0x0000_0008, dat=0xA5A5_0001, slave acks 1 cycle after stb) -> o_s_adr=0x08, o_grant=01, o_m0_ack for exactly 1 cycle, m1 outputs all 0.
REQ-035 m0 and m1 request in the same IDLE cycle, held for 3 transactions each -> grant order after reset is m0, m1, m0, m1, m0, m1, with one IDLE cycle between grants.
REQ-036 Slave never acks, TIMEOUT_CYCLES=4 -> o_m1_err=1 in the 4th BUSY cycle, o_s_stb=0 in that cycle, IDLE on the next cycle.
REQ-037 Ack arrives exactly in the timeout cycle -> ack=1, err=0, and i_s_rdt=0xDEAD_BEEF is returned to the owner.
REQ-038 Reset pulse while BUSY for m0 -> o_s_cyc=0 in the cycle after the edge, no ack/err, and the next contention after reset is granted to m0.
REQ-039 m1 drops cyc after 2 BUSY cycles -> IDLE on the next cycle with no termination, and a pending m0 request is granted on the following edge.

Source files
------------

// File: rtl/syscon_wb_arbiter_if.sv
// Bus bundle for the system-controller Wishbone arbiter.
// Carries both master request/response channels (m0 = CPU, m1 = debug), the
// forwarded slave request, the slave response and the one-hot grant.
//   slave  : arbiter view (it is the slave of the two masters) - samples i_*,
//            drives o_*.
//   master : environment view (the masters plus the syscon slave) - drives
//            i_*, samples o_*.
interface syscon_wb_arbiter_if #(
    parameter int SLV_AW = 6
);
    logic [31:0]       i_m0_adr, i_m1_adr;
    logic [31:0]       i_m0_dat, i_m1_dat;
    logic [3:0]        i_m0_sel, i_m1_sel;
    logic              i_m0_we, i_m0_cyc, i_m0_stb;
    logic              i_m1_we, i_m1_cyc, i_m1_stb;
    logic [31:0]       o_m0_rdt, o_m1_rdt;
    logic              o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [SLV_AW-1:0] o_s_adr;
    logic [31:0]       o_s_dat;
    logic [3:0]        o_s_sel;
    logic              o_s_we, o_s_cyc, o_s_stb;
    logic [31:0]       i_s_rdt;
    logic              i_s_ack;
    logic [1:0]        o_grant;

    modport slave (
        input  i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat, i_m0_sel, i_m1_sel,
        input  i_m0_we, i_m0_cyc, i_m0_stb, i_m1_we, i_m1_cyc, i_m1_stb,
        input  i_s_rdt, i_s_ack,
        output o_m0_rdt, o_m1_rdt, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err,
        output o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_s_stb, o_grant
    );

    modport master (
        output i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat, i_m0_sel, i_m1_sel,
        output i_m0_we, i_m0_cyc, i_m0_stb, i_m1_we, i_m1_cyc, i_m1_stb,
        output i_s_rdt, i_s_ack,
        input  o_m0_rdt, o_m1_rdt, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err,
        input  o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_s_stb, o_grant
    );
endinterface

// File: rtl/syscon_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the system-controller slave.
// Round-robin between m0 (CPU) and m1 (debug), m0 wins the first contention
// after reset. One transaction per grant, with a mandatory IDLE cycle between
// grants. A grant that sees no slave ack for TIMEOUT_CYCLES BUSY cycles is
// terminated with err to its owner.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - synchronous active-low reset
//   bus     - master/slave Wishbone bundle (syscon_wb_arbiter_if.slave)
module syscon_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,   // legal 2..255
    parameter int SLV_AW         = 6
) (
    input logic                i_clk,
    input logic                i_rst_n,
    syscon_wb_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    typedef struct packed {
        logic [SLV_AW-1:0] adr;
        logic [31:0]       dat;
        logic [3:0]        sel;
        logic              we;
        logic              cyc;
        logic              stb;
    } wb_req_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    wb_req_t m0, m1, own;
    logic    req0, req1, busy, tmo_hit;

    assign m0 = {bus.i_m0_adr[SLV_AW-1:0], bus.i_m0_dat, bus.i_m0_sel,
                 bus.i_m0_we, bus.i_m0_cyc, bus.i_m0_stb};
    assign m1 = {bus.i_m1_adr[SLV_AW-1:0], bus.i_m1_dat, bus.i_m1_sel,
                 bus.i_m1_we, bus.i_m1_cyc, bus.i_m1_stb};

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;
    assign own  = owner_q ? m1 : m0;

    // Reset is folded in so every output is quiet while i_rst_n is low,
    // even in the cycle before the reset edge takes effect.
    assign busy = (state_q == BUSY) & i_rst_n;

    // Timeout fires only while the owner still holds cyc (an abort wins) and
    // only without ack (an ack in the same cycle wins).
    assign tmo_hit = busy & own.cyc & (tmo_cnt_q == TMO_LAST) & ~bus.i_s_ack;

    // Slave request: combinational pass-through of the owner, killed in the
    // timeout cycle so the slave never sees a strobe the master won't accept.
    assign bus.o_s_adr = busy ? own.adr : '0;
    assign bus.o_s_dat = busy ? own.dat : '0;
    assign bus.o_s_sel = busy ? own.sel : '0;
    assign bus.o_s_we  = busy & own.we;
    assign bus.o_s_cyc = busy & own.cyc & ~tmo_hit;
    assign bus.o_s_stb = busy & own.stb & ~tmo_hit;

    assign bus.o_m0_ack = busy & ~owner_q & bus.i_s_ack;
    assign bus.o_m1_ack = busy &  owner_q & bus.i_s_ack;
    assign bus.o_m0_err = tmo_hit & ~owner_q;
    assign bus.o_m1_err = tmo_hit &  owner_q;
    assign bus.o_m0_rdt = (busy & ~owner_q) ? bus.i_s_rdt : '0;
    assign bus.o_m1_rdt = (busy &  owner_q) ? bus.i_s_rdt : '0;
    assign bus.o_grant  = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (req0 | req1) begin
                    state_d = BUSY;
                    // Contention goes to whoever was not granted last.
                    owner_d = (req0 & req1) ? ~last_q : req1;
                    last_d  = owner_d;
                end
            end
            BUSY: begin
                if (bus.i_s_ack | ~own.cyc | tmo_hit) begin
                    state_d   = IDLE;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
endmodule

// File: tb/tb_syscon_wb_arbiter.sv
// Bench for syscon_wb_arbiter: a cycle table for single transfers, timeout
// and ack-in-timeout-cycle, hand sequences for round-robin order, reset
// mid-transaction and abort, then random traffic against a transaction-level
// model of the arbiter.
module tb_syscon_wb_arbiter;
    localparam int T  = 4;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    syscon_wb_arbiter_if #(.SLV_AW(AW)) bus ();
    syscon_wb_arbiter #(.TIMEOUT_CYCLES(T), .SLV_AW(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic [31:0]   rdt0;
        logic          ack0, err0;
        logic [31:0]   rdt1;
        logic          ack1, err1;
        logic [AW-1:0] sadr;
        logic [31:0]   sdat;
        logic [3:0]    ssel;
        logic          swe, scyc, sstb;
        logic [1:0]    grant;
    } outs_t;

    typedef struct packed {
        logic [1:0]    req;    // bit N: master N holds cyc & stb
        logic          ack;
        logic [31:0]   rdt;
        logic [1:0]    grant;
        logic          scyc, sstb;
        logic [AW-1:0] sadr;
        logic          ack0, err0, ack1, err1;
        logic [31:0]   rdt0, rdt1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // stimulus
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic        we  [2];
    logic        cyc [2];
    logic        stb [2];
    logic        s_ack;
    logic [31:0] s_rdt;
    outs_t       cur;

    // model: who owns the slave (-1 = nobody), how many BUSY cycles have
    // already passed in this grant, and who was granted most recently
    int m_own  = -1;
    int m_age  = 0;
    int m_last = 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic outs_t model_out();
        outs_t o = '0;
        int    w;
        bit    tmo;
        if (rst_n && m_own >= 0) begin
            w   = m_own;
            tmo = (m_age == T - 1) && !s_ack && cyc[w];
            o.grant = (w == 0) ? 2'b01 : 2'b10;
            o.sadr  = adr[w][AW-1:0];
            o.sdat  = dat[w];
            o.ssel  = sel[w];
            o.swe   = we[w];
            o.scyc  = cyc[w] && !tmo;
            o.sstb  = stb[w] && !tmo;
            if (w == 0) begin o.rdt0 = s_rdt; o.ack0 = s_ack; o.err0 = tmo; end
            else        begin o.rdt1 = s_rdt; o.ack1 = s_ack; o.err1 = tmo; end
        end
        return o;
    endfunction

    task automatic model_step();
        bit r0, r1;
        r0 = cyc[0] && stb[0];
        r1 = cyc[1] && stb[1];
        if (!rst_n) begin
            m_own = -1; m_age = 0; m_last = 1;
        end else if (m_own < 0) begin
            if (r0 && r1)  m_own = 1 - m_last;
            else if (r0)   m_own = 0;
            else if (r1)   m_own = 1;
            if (m_own >= 0) begin m_last = m_own; m_age = 0; end
        end else if (s_ack || !cyc[m_own] || m_age == T - 1) begin
            m_own = -1;
        end else begin
            m_age++;
        end
    endtask

    function automatic outs_t dut_out();
        outs_t o;
        o.rdt0 = bus.o_m0_rdt; o.ack0 = bus.o_m0_ack; o.err0 = bus.o_m0_err;
        o.rdt1 = bus.o_m1_rdt; o.ack1 = bus.o_m1_ack; o.err1 = bus.o_m1_err;
        o.sadr = bus.o_s_adr;  o.sdat = bus.o_s_dat;  o.ssel = bus.o_s_sel;
        o.swe  = bus.o_s_we;   o.scyc = bus.o_s_cyc;  o.sstb = bus.o_s_stb;
        o.grant = bus.o_grant;
        return o;
    endfunction

    // Called just after a falling edge with the stimulus set up: applies it,
    // checks against the model mid-cycle, then lets one rising edge pass.
    task automatic tick();
        outs_t om, od;
        bus.i_m0_adr = adr[0]; bus.i_m1_adr = adr[1];
        bus.i_m0_dat = dat[0]; bus.i_m1_dat = dat[1];
        bus.i_m0_sel = sel[0]; bus.i_m1_sel = sel[1];
        bus.i_m0_we  = we[0];  bus.i_m1_we  = we[1];
        bus.i_m0_cyc = cyc[0]; bus.i_m1_cyc = cyc[1];
        bus.i_m0_stb = stb[0]; bus.i_m1_stb = stb[1];
        bus.i_s_ack  = s_ack;  bus.i_s_rdt  = s_rdt;
        #1;
        om  = model_out();
        od  = dut_out();
        cur = od;
        // slave adr/dat/sel/we carry no meaning while nobody owns the bus
        if (om.grant == 2'b00) begin
            om.sadr = '0; om.sdat = '0; om.ssel = '0; om.swe = 1'b0;
            od.sadr = '0; od.sdat = '0; od.ssel = '0; od.swe = 1'b0;
        end
        chk("model", 128'(od), 128'(om));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_req(input int m, input bit r);
        cyc[m] = r;
        stb[m] = r;
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic ack, input logic [31:0] rdt,
                                input logic [1:0] grant, input logic scyc, input logic sstb,
                                input logic [AW-1:0] sadr, input logic [3:0] terms,
                                input logic [31:0] rdt0, input logic [31:0] rdt1);
        vec_t v;
        v.req = req; v.ack = ack; v.rdt = rdt; v.grant = grant;
        v.scyc = scyc; v.sstb = sstb; v.sadr = sadr;
        {v.ack0, v.err0, v.ack1, v.err1} = terms;
        v.rdt0 = rdt0; v.rdt1 = rdt1;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0); set_req(1, 1'b0);
        s_ack = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    vec_t vt [15];

    initial begin
        // m0 = CPU write to 0x08, m1 = debug read at 0x1234_5670 (slave adr 0x30)
        adr[0] = 32'h0000_0008; dat[0] = 32'hA5A5_0001; sel[0] = 4'hF; we[0] = 1'b1;
        adr[1] = 32'h1234_5670; dat[1] = 32'h0000_0000; sel[1] = 4'hF; we[1] = 1'b0;
        s_rdt  = 32'h0;

        //            req    ack  rdt in        grant  cyc stb sadr   ak0/er0/ak1/er1 rdt0          rdt1
        vt[0]  = mk(2'b01, 0, 32'h5555_AAAA, 2'b00, 0, 0, 6'h00, 4'b0000, 32'h0,         32'h0);
        vt[1]  = mk(2'b01, 0, 32'h5555_AAAA, 2'b01, 1, 1, 6'h08, 4'b0000, 32'h5555_AAAA, 32'h0);
        vt[2]  = mk(2'b01, 1, 32'h1111_2222, 2'b01, 1, 1, 6'h08, 4'b1000, 32'h1111_2222, 32'h0);
        vt[3]  = mk(2'b00, 1, 32'h3333_4444, 2'b00, 0, 0, 6'h00, 4'b0000, 32'h0,         32'h0);
        vt[4]  = mk(2'b10, 0, 32'h0BAD_0001, 2'b00, 0, 0, 6'h00, 4'b0000, 32'h0,         32'h0);
        vt[5]  = mk(2'b10, 0, 32'h0BAD_0001, 2'b10, 1, 1, 6'h30, 4'b0000, 32'h0,         32'h0BAD_0001);
        vt[6]  = mk(2'b10, 0, 32'h0BAD_0001, 2'b10, 1, 1, 6'h30, 4'b0000, 32'h0,         32'h0BAD_0001);
        vt[7]  = mk(2'b10, 0, 32'h0BAD_0001, 2'b10, 1, 1, 6'h30, 4'b0000, 32'h0,         32'h0BAD_0001);
        vt[8]  = mk(2'b10, 0, 32'h0BAD_0001, 2'b10, 0, 0, 6'h30, 4'b0001, 32'h0,         32'h0BAD_0001);
        vt[9]  = mk(2'b10, 0, 32'h0BAD_0001, 2'b00, 0, 0, 6'h00, 4'b0000, 32'h0,         32'h0);
        vt[10] = mk(2'b10, 0, 32'h0BAD_0001, 2'b10, 1, 1, 6'h30, 4'b0000, 32'h0,         32'h0BAD_0001);
        vt[11] = mk(2'b10, 0, 32'h0BAD_0001, 2'b10, 1, 1, 6'h30, 4'b0000, 32'h0,         32'h0BAD_0001);
        vt[12] = mk(2'b10, 0, 32'h0BAD_0001, 2'b10, 1, 1, 6'h30, 4'b0000, 32'h0,         32'h0BAD_0001);
        vt[13] = mk(2'b10, 1, 32'hDEAD_BEEF, 2'b10, 1, 1, 6'h30, 4'b0010, 32'h0,         32'hDEAD_BEEF);
        vt[14] = mk(2'b00, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 6'h00, 4'b0000, 32'h0,         32'h0);

        // reset state: every output low while reset is held
        do_reset();
        chk("reset_outs", 128'(cur), 128'(0));

        // single write, timeout on m1, ack landing in the timeout cycle
        foreach (vt[i]) begin
            set_req(0, vt[i].req[0]);
            set_req(1, vt[i].req[1]);
            s_ack = vt[i].ack;
            s_rdt = vt[i].rdt;
            tick();
            chk($sformatf("vec[%0d]", i),
                128'({cur.grant, cur.scyc, cur.sstb, cur.ack0, cur.err0, cur.ack1, cur.err1, cur.rdt0, cur.rdt1}),
                128'({vt[i].grant, vt[i].scyc, vt[i].sstb, vt[i].ack0, vt[i].err0,
                      vt[i].ack1, vt[i].err1, vt[i].rdt0, vt[i].rdt1}));
            if (vt[i].grant != 2'b00)
                chk($sformatf("vec[%0d].sadr", i), 128'(cur.sadr), 128'(vt[i].sadr));
        end

        // round robin with both masters holding requests; slave acks at once
        do_reset();
        set_req(0, 1'b1); set_req(1, 1'b1);
        s_ack = 1'b1; s_rdt = 32'h0000_00C3;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rr_grant[%0d]", k), 128'(cur.grant),
                128'((k % 2 == 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10)));
        end

        // reset while m0 is BUSY: last must return to m1 so m0 wins again
        set_req(0, 1'b0); set_req(1, 1'b0); s_ack = 1'b0;
        tick();                                   // drain to IDLE
        set_req(0, 1'b1);
        tick();                                   // m0 granted, last = m0
        set_req(1, 1'b1);
        rst_n = 1'b0;
        tick();                                   // BUSY m0 but reset held
        chk("rst_busy_outs", 128'(cur), 128'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_after", 128'({cur.grant, cur.scyc, cur.sstb, cur.ack0, cur.err0, cur.ack1, cur.err1}), 128'(0));
        s_ack = 1'b1;
        tick();
        chk("rst_regrant_m0", 128'({cur.grant, cur.ack0}), 128'({2'b01, 1'b1}));

        // m1 aborts after two BUSY cycles, pending m0 granted right after
        s_ack = 1'b0;
        tick();                                   // IDLE, m1 wins contention
        tick();
        chk("abort_busy1", 128'(cur.grant), 128'(2'b10));
        tick();
        chk("abort_busy2", 128'(cur.grant), 128'(2'b10));
        set_req(1, 1'b0);
        tick();
        chk("abort_cycle", 128'({cur.grant, cur.scyc, cur.sstb, cur.ack1, cur.err1}), 128'({2'b10, 4'b0000}));
        tick();
        chk("abort_idle", 128'({cur.grant, cur.ack0, cur.err0, cur.ack1, cur.err1}), 128'(0));
        tick();
        chk("abort_m0_grant", 128'({cur.grant, cur.scyc}), 128'({2'b01, 1'b1}));

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int m = 0; m < 2; m++) begin
                cyc[m] = ($urandom_range(0, 3) != 0);
                stb[m] = ($urandom_range(0, 3) != 0);
                adr[m] = $urandom;
                dat[m] = $urandom;
                sel[m] = 4'($urandom);
                we[m]  = 1'($urandom);
            end
            s_ack = ($urandom_range(0, 3) == 0);
            s_rdt = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
